lcd_line_formatter: RTL and testbench



---
 rtl/lcd_line_formatter.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_line_formatter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_formatter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_line_formatter
// Purpose  : Feeds a 16x2 character-LCD driver. Converts two 32-bit binary
//            values to right-aligned decimal ASCII with a sequential
//            double-dabble (shift-add-3) engine, then packs them into two
//            16-character line buffers. Both buffers are committed in the
//            same cycle, so the driver never sees a half-written line.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            start    - conversion request, sampled only while idle
//            value_a  - line A value, latched when start is accepted
//            value_b  - line B value, latched when start is accepted
//            stringA  - line A, char 0 in bits [0:7], MSB first
//            stringB  - line B, same packing
//            busy     - high while a conversion is in flight
//            done     - one-cycle pulse when both lines are committed
// Options  : LCD_SIGNED_EN - treat inputs as two's complement and show a
//            '-' in the sign slot for negative values.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_line_formatter #(
  parameter logic [7:0] LABEL_A  = 8'h41,
  parameter logic [7:0] LABEL_B  = 8'h42,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  value_a,
  input  logic [31:0]  value_b,
  output logic [0:127] stringA,
  output logic [0:127] stringB,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_SHIFT_A = 3'd2,
    S_FMT_A   = 3'd3,
    S_LOAD_B  = 3'd4,
    S_SHIFT_B = 3'd5,
    S_FMT_B   = 3'd6,
    S_COMMIT  = 3'd7
  } state_t;

  state_t       state_q;
  logic [31:0]  val_a_q;
  logic [31:0]  val_b_q;
  logic [39:0]  bcd_q;
  logic [31:0]  shift_q;
  logic [4:0]   cnt_q;
  logic [0:127] stage_a_q;
  logic [0:127] stage_b_q;

  logic [38:0]  bcd_adj;
  logic [39:0]  bcd_d;
  logic [31:0]  shift_d;
  logic [31:0]  load_src;
  logic [31:0]  load_mag_d;
  logic         cnt_last;
  logic [0:127] line_d;
  logic         seen_d;
  logic [3:0]   nib_d;

`ifdef LCD_SIGNED_EN
  logic         neg_q;
  logic         load_neg_d;
`endif

  // ---------------------------------------------------------------------------
  // Double-dabble datapath: add 3 to every nibble >= 5, then shift left one.
  // The top digit never exceeds 4 for a 32-bit magnitude (max 4294967295),
  // so it never needs the adjust and its MSB can never be shifted out.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end
  endgenerate
  assign bcd_adj[38:36] = bcd_q[38:36];

  assign bcd_d    = {bcd_adj, shift_q[31]};
  assign shift_d  = {shift_q[30:0], 1'b0};
  assign cnt_last = (cnt_q == 5'd31);

  // One shared engine serves both lines; the LOAD state picks the source.
  assign load_src = (state_q == S_LOAD_A) ? val_a_q : val_b_q;

`ifdef LCD_SIGNED_EN
  // 32'h80000000 negates to itself, which is the correct unsigned magnitude.
  assign load_neg_d = load_src[31];
  assign load_mag_d = load_src[31] ? (~load_src + 32'd1) : load_src;
`else
  assign load_mag_d = load_src;
`endif

  // ---------------------------------------------------------------------------
  // Line image from the finished BCD register. Digits are scanned from the
  // most significant (char 3) down; leading zeros stay blank, and the last
  // digit (char 12) is always shown so that zero renders as a single '0'.
  // ---------------------------------------------------------------------------
  always_comb begin
    line_d        = {16{PAD_CHAR}};
    seen_d        = 1'b0;
    nib_d         = 4'd0;
    line_d[0:7]   = (state_q == S_FMT_A) ? LABEL_A : LABEL_B;
    line_d[8:15]  = 8'h3D;
`ifdef LCD_SIGNED_EN
    line_d[16:23] = neg_q ? 8'h2D : PAD_CHAR;
`endif
    for (int k = 0; k < 10; k++) begin
      nib_d = bcd_q[4*(9-k) +: 4];
      if ((nib_d != 4'd0) || (k == 9)) begin
        seen_d = 1'b1;
      end
      if (seen_d) begin
        line_d[8*(3+k) +: 8] = {4'h3, nib_d};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer and all registered state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      val_a_q   <= 32'd0;
      val_b_q   <= 32'd0;
      bcd_q     <= 40'd0;
      shift_q   <= 32'd0;
      cnt_q     <= 5'd0;
      stage_a_q <= {16{PAD_CHAR}};
      stage_b_q <= {16{PAD_CHAR}};
      stringA   <= {16{PAD_CHAR}};
      stringB   <= {16{PAD_CHAR}};
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LCD_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            val_a_q <= value_a;
            val_b_q <= value_b;
            busy    <= 1'b1;
            state_q <= S_LOAD_A;
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          bcd_q   <= 40'd0;
          shift_q <= load_mag_d;
          cnt_q   <= 5'd0;
`ifdef LCD_SIGNED_EN
          neg_q   <= load_neg_d;
`endif
          state_q <= (state_q == S_LOAD_A) ? S_SHIFT_A : S_SHIFT_B;
        end

        S_SHIFT_A, S_SHIFT_B: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_last) begin
            state_q <= (state_q == S_SHIFT_A) ? S_FMT_A : S_FMT_B;
          end
        end

        S_FMT_A: begin
          stage_a_q <= line_d;
          state_q   <= S_LOAD_B;
        end

        S_FMT_B: begin
          stage_b_q <= line_d;
          state_q   <= S_COMMIT;
        end

        S_COMMIT: begin
          stringA <= stage_a_q;
          stringB <= stage_b_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_line_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_line_formatter
// Purpose  : Self-checking bench for lcd_line_formatter. Expected lines come
//            from literal tables and an independent decimal formatting model;
//            they are queued at start and compared when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_line_formatter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  value_a;
  logic [31:0]  value_b;
  logic [0:127] stringA;
  logic [0:127] stringB;
  logic         busy;
  logic         done;

  lcd_line_formatter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .value_a (value_a),
    .value_b (value_b),
    .stringA (stringA),
    .stringB (stringB),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  va;
    logic [31:0]  vb;
    logic [127:0] ea;
    logic [127:0] eb;
  } vec_t;

  localparam logic [127:0] BLANK = {16{8'h20}};

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   done_cnt = 0;
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Independent reference: decimal digits by repeated division.
  function automatic logic [127:0] model(input logic [7:0] lab, input logic [31:0] v);
    logic [127:0] s;
    logic [31:0]  m;
    bit           neg;
    int           pos;
    s   = BLANK;
    m   = v;
    neg = 1'b0;
`ifdef LCD_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      m   = 32'd0 - v;
    end
`endif
    s[127:120] = lab;
    s[119:112] = 8'h3D;
    if (neg) s[111:104] = 8'h2D;
    pos = 12;
    do begin
      s[127-8*pos -: 8] = 8'h30 + 8'(m % 32'd10);
      m   = m / 32'd10;
      pos = pos - 1;
    end while (m != 32'd0);
    return s;
  endfunction

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk_int("unexpected_done", 1, 0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("stringA", stringA, e.ea);
        chk("stringB", stringB, e.eb);
      end
    end
  end

  task automatic launch(input vec_t v, input bit expect_it);
    start   = 1'b1;
    value_a = v.va;
    value_b = v.vb;
    if (expect_it) exp_q.push_back(v);
  endtask

  // Called right after launch at a falling edge; drops start and scrambles
  // the inputs after the accepting edge, and counts until done is seen.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start   = 1'b0;
        value_a = $urandom;
        value_b = $urandom;
      end
      if (busy) bc++;
    end while (!done && cyc < 300);
  endtask

  vec_t vecs[8];

  initial begin
    int   cyc;
    int   bc;
    int   d0;
    vec_t v;
    vec_t v2;
    logic [127:0] last_a;

    vecs[0] = '{32'd0, 32'hFFFFFFFF,
                {"A=", {10{8'h20}}, "0   "},
                {"B=", 8'h20, "4294967295", "   "}};
    vecs[1] = '{32'd1234, 32'd1000000000,
                {"A=", {7{8'h20}}, "1234", "   "},
                {"B=", 8'h20, "1000000000", "   "}};
`ifdef LCD_SIGNED_EN
    vecs[2] = '{32'hFFFFFFFF, 32'h80000000,
                {"A=-", {9{8'h20}}, "1   "},
                {"B=-", "2147483648", "   "}};
`else
    vecs[2] = '{32'hFFFFFFFF, 32'h80000000,
                {"A=", 8'h20, "4294967295", "   "},
                {"B=", 8'h20, "2147483648", "   "}};
`endif
    vecs[3] = '{32'd9, 32'd10, model(8'h41, 32'd9), model(8'h42, 32'd10)};
    vecs[4] = '{32'd99999, 32'd7, model(8'h41, 32'd99999), model(8'h42, 32'd7)};
    vecs[5] = '{32'd100, 32'd1000000001, model(8'h41, 32'd100), model(8'h42, 32'd1000000001)};
    vecs[6] = '{32'd5, 32'd12345678, model(8'h41, 32'd5), model(8'h42, 32'd12345678)};
    vecs[7] = '{32'd999999999, 32'd55555, model(8'h41, 32'd999999999), model(8'h42, 32'd55555)};

    // Reset
    rst = 1'b1; start = 1'b0; value_a = 32'd0; value_b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stringA", stringA, BLANK);
    chk("reset_stringB", stringB, BLANK);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);

    // Table-driven conversions with latency / busy-width / pulse-width checks
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i], 1'b1);
      wait_done(cyc, bc);
      chk_int($sformatf("latency_%0d", i), cyc - 1, 69);
      chk_int($sformatf("busy_cycles_%0d", i), bc, 69);
      @(negedge clk);
      chk_int($sformatf("done_pulse_%0d", i), int'(done), 0);
      repeat (2) @(negedge clk);
    end
    last_a = vecs[7].ea;

    // Second start mid-conversion is ignored; lines stay stable until commit
    d0 = done_cnt;
    launch(vecs[1], 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1)  start = 1'b0;
      if (cyc == 20) begin
        start = 1'b1; value_a = 32'd777; value_b = 32'd888;
      end
      if (cyc == 21) start = 1'b0;
      if (cyc == 30) chk("stable_stringA", stringA, last_a);
    end while (!done && cyc < 300);
    chk_int("ignored_start_latency", cyc - 1, 69);
    repeat (100) @(negedge clk);
    chk_int("ignored_start_one_done", done_cnt - d0, 1);

    // Reset mid-operation aborts, blanks the lines and produces no done
    d0 = done_cnt;
    v  = '{32'd42, 32'd43, BLANK, BLANK};
    launch(v, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_int("abort_busy", int'(busy), 0);
    chk("abort_stringA", stringA, BLANK);
    chk("abort_stringB", stringB, BLANK);
    repeat (100) @(negedge clk);
    chk_int("abort_no_done", done_cnt - d0, 0);
    launch(vecs[4], 1'b1);
    wait_done(cyc, bc);
    chk_int("after_abort_latency", cyc - 1, 69);
    repeat (2) @(negedge clk);

    // start held high: back-to-back conversions with one idle cycle between
    v  = '{32'd31415, 32'd27182, model(8'h41, 32'd31415), model(8'h42, 32'd27182)};
    v2 = '{32'd600, 32'd4000000000, model(8'h41, 32'd600), model(8'h42, 32'd4000000000)};
    launch(v, 1'b1);
    exp_q.push_back(v2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    chk_int("b2b_first_latency", cyc - 1, 69);
    value_a = v2.va;
    value_b = v2.vb;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    chk_int("b2b_done_gap", cyc, 70);
    repeat (100) @(negedge clk);
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
